regfile_write_arbiter: RTL

Sequences and shares the single write port of the 32-entry register file. After reset it sweeps every register to zero, since the register file itself has no reset. It then arbitrates round-robin between two writeback requesters, the ALU and the load path, and drives the register file's `RegWrite`, `write_address` and `write_data` from registered outputs. Writes to register 0 can be suppressed so that r0 reads as a constant zero.

---
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for a 32-entry register file: zeroes every entry after reset, then
// arbitrates round-robin between ALU and load-path writeback with registered write outputs.
module regfile_write_arbiter #(
    parameter int unsigned data_width       = 32,
    parameter int unsigned addr_width       = 5,
    parameter bit          zero_reg_protect = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [addr_width-1:0] alu_addr,
    input  logic [data_width-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [addr_width-1:0] mem_addr,
    input  logic [data_width-1:0] mem_data,
    output logic                  RegWrite,
    output logic [addr_width-1:0] write_address,
    output logic [data_width-1:0] write_data,
    output logic                  init_busy,
    output logic                  last_grant
);

    localparam int unsigned num_regs = 2 ** addr_width;
    localparam logic [addr_width:0] last_idx = (addr_width + 1)'(num_regs - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e                state_q, state_d;
    logic [addr_width:0]   cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  reg_write_q, reg_write_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic                  alu_win, mem_win;

    // last_grant_q == 1 means the load path went last, so the ALU wins a tie.
    always_comb begin
        alu_win = 1'b0;
        mem_win = 1'b0;
        if (state_q == StRun) begin
            alu_win = alu_valid && (!mem_valid || last_grant_q);
            mem_win = mem_valid && !alu_win;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        reg_write_d  = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            StClear: begin
                reg_write_d = 1'b1;
                waddr_d     = cnt_q[addr_width-1:0];
                wdata_d     = '0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == last_idx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (alu_win) begin
                    waddr_d      = alu_addr;
                    wdata_d      = alu_data;
                    reg_write_d  = !(zero_reg_protect && (alu_addr == '0));
                    last_grant_d = 1'b0;
                end else if (mem_win) begin
                    waddr_d      = mem_addr;
                    wdata_d      = mem_data;
                    reg_write_d  = !(zero_reg_protect && (mem_addr == '0));
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StClear;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            reg_write_q  <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign alu_ready     = alu_win;
    assign mem_ready     = mem_win;
    assign RegWrite      = reg_write_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign init_busy     = (state_q == StClear);
    assign last_grant    = last_grant_q;

endmodule
